// File: rtl/ef_spi_slave_responder.sv
// rtl/ef_spi_slave_responder.sv - oversampled SPI slave with TX/RX word FIFOs.
// Optional EF_SPI_RESP_ECHO_EN: an empty TX FIFO replays the last received word instead of FILL.
module ef_spi_slave_responder #(
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [DW-1:0] FILL = 8'hFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk,
  input  logic          csb,
  input  logic          mosi,
  output logic          miso,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic [DW-1:0] rx_data,
  input  logic          rx_rd,
  output logic          rx_empty,
  output logic          rx_ovf,
  input  logic          ovf_clr,
  output logic          word_done,
  output logic          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DW);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [2:0] sclk_q, csb_q;
  logic [1:0] mosi_q;
  logic [DW-1:0] tx_shift, rx_shift, load_word, fill_word;
  logic [CW-1:0] bit_cnt;
  logic skip;
  logic load_tx, do_sample, shift_ev, rx_push;

  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr, rx_rd_nxt;
  logic tx_empty, rx_full, tx_push, tx_pop, rx_push_ok, rx_pop;

  wire sclk_rise = sclk_q[1] & ~sclk_q[2];
  wire sclk_fall = ~sclk_q[1] & sclk_q[2];
  wire lead_edge = CPOL ? sclk_fall : sclk_rise;
  wire trail_edge = CPOL ? sclk_rise : sclk_fall;
  wire sample_edge = CPHA ? trail_edge : lead_edge;
  wire shift_edge = CPHA ? lead_edge : trail_edge;
  wire csb_fall = ~csb_q[1] & csb_q[2];
  wire csb_rise = csb_q[1] & ~csb_q[2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= {3{CPOL}};
      csb_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      csb_q  <= {csb_q[1:0], csb};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) && (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) && (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

  assign tx_push    = tx_wr && !tx_full;
  assign tx_pop     = load_tx && !tx_empty;
  assign rx_push_ok = rx_push && !rx_full;
  assign rx_pop     = rx_rd && !rx_empty;
  assign rx_rd_nxt  = rx_rd_ptr + (rx_pop ? PTR_ONE : '0);

`ifdef EF_SPI_RESP_ECHO_EN
  logic [DW-1:0] last_rx;
  always_ff @(posedge clk_i) begin
    if (rst_i) last_rx <= FILL;
    else if (rx_push) last_rx <= rx_shift;
  end
  // A word finishing this cycle is not yet in last_rx, so forward it directly.
  assign fill_word = rx_push ? rx_shift : last_rx;
`else
  assign fill_word = FILL;
`endif

  assign load_word = tx_empty ? fill_word : tx_mem[tx_rd_ptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    load_tx   = 1'b0;
    do_sample = 1'b0;
    shift_ev  = 1'b0;
    rx_push   = 1'b0;
    word_done = 1'b0;
    miso      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall) begin
          load_tx   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        busy = 1'b1;
        miso = tx_shift[DW-1];
        if (bit_cnt == CNT_FULL) begin
          word_done = 1'b1;
          rx_push   = 1'b1;
        end
        if (csb_rise) begin
          state_nxt = IDLE;
        end else if (bit_cnt == CNT_FULL) begin
          load_tx = 1'b1;
        end else begin
          do_sample = sample_edge;
          shift_ev  = shift_edge;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // skip suppresses the shift edge that would otherwise drop the freshly loaded MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      skip     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (load_tx) begin
        tx_shift <= load_word;
        bit_cnt  <= '0;
        skip     <= 1'b1;
      end else begin
        if (rx_push) bit_cnt <= '0;
        if (do_sample) begin
          rx_shift <= {rx_shift[DW-2:0], mosi_q[1]};
          bit_cnt  <= bit_cnt + CW'(1);
          if (!CPHA) skip <= 1'b0;
        end
        if (shift_ev) begin
          if (!skip) tx_shift <= {tx_shift[DW-2:0], 1'b0};
          skip <= ~CPHA;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= tx_data;
    if (rx_push_ok) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_data   <= '0;
      rx_ovf    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      rx_rd_ptr <= rx_rd_nxt;
      // Register the post-update head, bypassing a write into the slot being exposed.
      if (rx_push_ok && (rx_rd_nxt[AW-1:0] == rx_wr_ptr[AW-1:0])) rx_data <= rx_shift;
      else rx_data <= rx_mem[rx_rd_nxt[AW-1:0]];
      if (rx_push && rx_full) rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ef_spi_slave_responder.sv
// tb/tb_ef_spi_slave_responder.sv - directed scoreboard bench, one DUT per SPI mode.
module tb_ef_spi_slave_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0] sclk, csb, mosi, tx_wr, rx_rd, ovf_clr;
  wire  [3:0] miso, tx_full, rx_empty, rx_ovf, word_done, busy;
  logic [7:0] tx_data [4];
  wire  [7:0] rx_data [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      ef_spi_slave_responder #(
        .DW(8), .FIFO_DEPTH(4), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .FILL(8'hFF)
      ) u_dut (
        .clk_i(clk), .rst_i(rst), .sclk(sclk[g]), .csb(csb[g]), .mosi(mosi[g]),
        .miso(miso[g]), .tx_data(tx_data[g]), .tx_wr(tx_wr[g]), .tx_full(tx_full[g]),
        .rx_data(rx_data[g]), .rx_rd(rx_rd[g]), .rx_empty(rx_empty[g]), .rx_ovf(rx_ovf[g]),
        .ovf_clr(ovf_clr[g]), .word_done(word_done[g]), .busy(busy[g])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  int wd_cnt = 0;
  int wd_base;
  logic [7:0] exp_miso_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] rd;

  always @(negedge clk) if (word_done[0]) wd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input int m, input logic [7:0] d);
    tx_data[m] = d;
    tx_wr[m] = 1'b1;
    @(negedge clk);
    tx_wr[m] = 1'b0;
  endtask

  // Master model: half sclk period = 4 clk cycles; n sclk edges of word 'out'.
  task automatic edges(input int m, input logic [7:0] out, input int n, output logic [7:0] din);
    logic cpol, cpha;
    cpol = (m / 2) != 0;
    cpha = (m % 2) != 0;
    din = 8'h00;
    for (int e = 0; e < n; e++) begin
      int i;
      i = 7 - e / 2;
      if ((e % 2) == 0 && !cpha) mosi[m] = out[i];
      cyc(4);
      sclk[m] = ((e % 2) == 0) ? ~cpol : cpol;
      if ((e % 2) == 0 && cpha) mosi[m] = out[i];
      if ((e % 2) == int'(cpha)) din[i] = miso[m];
    end
  endtask

  task automatic xfer(input int m, input logic [7:0] out, input logic [7:0] exp_rd, input bit store);
    logic [7:0] got;
    exp_miso_q.push_back(exp_rd);
    if (store) exp_rx_q.push_back(out);
    edges(m, out, 16, got);
    chk($sformatf("miso_word_m%0d", m), got, exp_miso_q.pop_front());
  endtask

  task automatic frame_end(input int m);
    cyc(4);
    csb[m] = 1'b1;
    cyc(4);
  endtask

  task automatic pop_rx(input int m, input string tag);
    chk({tag, "_nonempty"}, rx_empty[m], 1'b0);
    chk(tag, rx_data[m], exp_rx_q.pop_front());
    rx_rd[m] = 1'b1;
    @(negedge clk);
    rx_rd[m] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    sclk = 4'b1100;
    csb = 4'b1111;
    mosi = 4'b0000;
    tx_wr = 4'b0000;
    rx_rd = 4'b0000;
    ovf_clr = 4'b0000;
    for (int m = 0; m < 4; m++) tx_data[m] = 8'h00;
    cyc(3);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_miso_m%0d", m), miso[m], 1'b0);
      chk($sformatf("rst_tx_full_m%0d", m), tx_full[m], 1'b0);
      chk($sformatf("rst_rx_empty_m%0d", m), rx_empty[m], 1'b1);
      chk($sformatf("rst_rx_ovf_m%0d", m), rx_ovf[m], 1'b0);
      chk($sformatf("rst_word_done_m%0d", m), word_done[m], 1'b0);
      chk($sformatf("rst_busy_m%0d", m), busy[m], 1'b0);
      chk($sformatf("rst_rx_data_m%0d", m), rx_data[m], 8'h00);
    end
    rst = 1'b0;
    cyc(2);

    // Single word with a queued TX word.
    push_tx(0, 8'hA5);
    csb[0] = 1'b0;
    xfer(0, 8'h3C, 8'hA5, 1);
    frame_end(0);
    chk("t1_word_done_count", wd_cnt, 1);
    pop_rx(0, "t1_rx");
    chk("t1_rx_empty_after", rx_empty[0], 1'b1);

    // Back-to-back words with empty TX FIFO.
    csb[0] = 1'b0;
    xfer(0, 8'h12, 8'hFF, 1);
    xfer(0, 8'h34, 8'hFF, 1);
    frame_end(0);
    chk("t2_word_done_count", wd_cnt, 3);
    pop_rx(0, "t2_rx0");
    pop_rx(0, "t2_rx1");
    chk("t2_rx_empty_after", rx_empty[0], 1'b1);

    // Overflow: five words into a four-entry RX FIFO.
    csb[0] = 1'b0;
    for (int k = 0; k < 5; k++) xfer(0, 8'h40 + 8'(k), 8'hFF, k < 4);
    frame_end(0);
    chk("t3_rx_ovf_set", rx_ovf[0], 1'b1);
    ovf_clr[0] = 1'b1;
    cyc(1);
    ovf_clr[0] = 1'b0;
    cyc(1);
    chk("t3_rx_ovf_clr", rx_ovf[0], 1'b0);
    for (int k = 0; k < 4; k++) pop_rx(0, $sformatf("t3_rx%0d", k));
    chk("t3_rx_empty_after", rx_empty[0], 1'b1);

    // Abort after three sclk edges.
    wd_base = wd_cnt;
    csb[0] = 1'b0;
    edges(0, 8'hF0, 3, rd);
    csb[0] = 1'b1;
    cyc(2);
    chk("t4_busy_before_sync", busy[0], 1'b1);
    cyc(1);
    chk("t4_busy_after_3", busy[0], 1'b0);
    sclk[0] = 1'b0;
    cyc(4);
    chk("t4_no_rx_push", rx_empty[0], 1'b1);
    chk("t4_no_word_done", wd_cnt, wd_base);
    push_tx(0, 8'h5A);
    csb[0] = 1'b0;
    xfer(0, 8'h96, 8'h5A, 1);
    frame_end(0);
    pop_rx(0, "t4_rx_next");

    // Mode sweep.
    for (int m = 0; m < 4; m++) begin
      push_tx(m, 8'h81);
      csb[m] = 1'b0;
      xfer(m, 8'h7E, 8'h81, 1);
      frame_end(m);
      pop_rx(m, $sformatf("t5_rx_m%0d", m));
    end

    // Reset in the middle of a word, with data in both FIFOs.
    csb[0] = 1'b0;
    xfer(0, 8'h11, 8'hFF, 0);
    frame_end(0);
    push_tx(0, 8'h33);
    push_tx(0, 8'hC3);
    csb[0] = 1'b0;
    edges(0, 8'hA5, 8, rd);
    chk("t6_busy_midword", busy[0], 1'b1);
    rst = 1'b1;
    cyc(1);
    chk("t6_rst_miso", miso[0], 1'b0);
    chk("t6_rst_busy", busy[0], 1'b0);
    chk("t6_rst_rx_empty", rx_empty[0], 1'b1);
    chk("t6_rst_rx_data", rx_data[0], 8'h00);
    chk("t6_rst_tx_full", tx_full[0], 1'b0);
    chk("t6_rst_rx_ovf", rx_ovf[0], 1'b0);
    chk("t6_rst_word_done", word_done[0], 1'b0);
    csb[0] = 1'b1;
    sclk[0] = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    csb[0] = 1'b0;
    xfer(0, 8'h6B, 8'hFF, 1);
    frame_end(0);
    pop_rx(0, "t6_rx_next");
    chk("t6_rx_empty_after", rx_empty[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
